tkm_serial_addsub: RTL and testbench

Bit-serial adder/subtractor for the tkmdemo tile. The tile's combinational half-adder produces sum and carry in one step. This block goes the other way: it accepts two WIDTH-bit operands through a valid/ready handshake and computes A+B or A−B one bit per clock, LSB first, through a single full adder/subtractor cell and a carry/borrow flop. It returns the result word and the final carry/borrow through a second handshake. It sits inside the tt_um wrapper, which drives `rst` from the inverted pad reset and maps operands from ui_in/uio_in.

---
 rtl/tkm_serial_addsub.sv | 105 ++++++++++
 tb/tb_tkm_serial_addsub.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tkm_serial_addsub.sv
// Bit-serial adder/subtractor: one full add/sub cell plus a carry/borrow flop,
// operands in and result out through valid/ready handshakes, LSB first.
module tkm_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             busy,
    output logic             ser_bit,
    output logic             ser_valid
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             mode_reg;
    logic             flag_reg;
    logic [CW-1:0]    cnt_reg;

    logic x_bit;
    logic y_bit;
    logic sum_bit;
    logic carry_next;
    logic last_bit;

    // One cell serves both modes: only the carry/borrow generate term differs.
    assign x_bit      = a_sh_reg[0];
    assign y_bit      = b_sh_reg[0];
    assign sum_bit    = x_bit ^ y_bit ^ carry_reg;
    assign carry_next = mode_reg ? ((~x_bit & y_bit) | (~(x_bit ^ y_bit) & carry_reg))
                                 : ((x_bit & y_bit) | (carry_reg & (x_bit ^ y_bit)));
    assign last_bit   = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            mode_reg   <= 1'b0;
            flag_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        mode_reg  <= op_sub;
                        carry_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Result fills from the MSB end so bit 0 lands at the LSB after WIDTH shifts.
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    result_reg <= {sum_bit, result_reg[WIDTH-1:1]};
                    carry_reg  <= carry_next;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        flag_reg  <= carry_next;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign busy      = (state_reg == S_RUN);
    assign ser_valid = (state_reg == S_RUN);
    assign ser_bit   = (state_reg == S_RUN) & sum_bit;
    assign out_valid = (state_reg == S_DONE);
    assign result    = result_reg;
    assign flag      = flag_reg;

endmodule

// File: tb/tb_tkm_serial_addsub.sv
// Directed bench for tkm_serial_addsub: add/sub vectors, bit stream,
// backpressure, ignored input during RUN, and reset mid-operation.
module tb_tkm_serial_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       op_sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag;
    logic       busy;
    logic       ser_bit;
    logic       ser_valid;

    int checks = 0;
    int errors = 0;

    tkm_serial_addsub #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag),
        .busy      (busy),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold>0 keeps out_ready low that many cycles in DONE
    // and pulses a bogus in_valid during RUN.
    task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic sub, input logic [7:0] exp_res, input logic exp_flag,
                          input int hold);
        logic [7:0] er;
        er = exp_res;
        out_ready = (hold == 0);
        a = av; b = bv; op_sub = sub; in_valid = 1'b1;
        chk({name, " in_ready_idle"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a = 8'h00; b = 8'h00; op_sub = ~sub;
        chk({name, " in_ready_run"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (hold != 0 && i == 3) begin
                in_valid = 1'b1; a = 8'hAA;
            end
            if (i == 4) in_valid = 1'b0;
            chk($sformatf("%s busy[%0d]", name, i), 32'(busy), 32'd1);
            chk($sformatf("%s ser_valid[%0d]", name, i), 32'(ser_valid), 32'd1);
            chk($sformatf("%s ser_bit[%0d]", name, i), 32'(ser_bit), 32'(er[i]));
            chk($sformatf("%s out_valid_run[%0d]", name, i), 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk({name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({name, " busy_done"}, 32'(busy), 32'd0);
        chk({name, " result"}, 32'(result), 32'(exp_res));
        chk({name, " flag"}, 32'(flag), 32'(exp_flag));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk($sformatf("%s hold_valid[%0d]", name, h), 32'(out_valid), 32'd1);
            chk($sformatf("%s hold_result[%0d]", name, h), 32'(result), 32'(exp_res));
            chk($sformatf("%s hold_flag[%0d]", name, h), 32'(flag), 32'(exp_flag));
            chk($sformatf("%s hold_in_ready[%0d]", name, h), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk({name, " in_ready_after"}, 32'(in_ready), 32'd1);
        chk({name, " out_valid_after"}, 32'(out_valid), 32'd0);
        chk({name, " result_kept"}, 32'(result), 32'(exp_res));
        $display("txn %s: a=%02h b=%02h sub=%0d -> result=%02h flag=%0d", name, av, bv, sub, result, flag);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ser_valid", 32'(ser_valid), 32'd0);
        chk("reset ser_bit", 32'(ser_bit), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset flag", 32'(flag), 32'd0);
        $display("txn reset: in_ready=%0d result=%02h", in_ready, result);

        run_op("add3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 0);
        run_op("sub03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, 0);
        run_op("sub05_03", 8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 0);
        run_op("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run_op("sub80_80", 8'h80, 8'h80, 1'b1, 8'h00, 1'b0, 0);
        run_op("sub00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 0);
        run_op("bp_add", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 5);
        run_op("after_bp", 8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 0);

        // Abort after three bits.
        out_ready = 1'b1;
        a = 8'h12; b = 8'h34; op_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort flag", 32'(flag), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("abort no_out_valid", 32'(seen), 32'd0);
        $display("txn abort: in_ready=%0d result=%02h out_valid_seen=%0d", in_ready, result, seen);
        run_op("add12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
